// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-RAM arbiter.
// The owner encoding is used by both the round-robin core and the top level.
package dmem_arb_pkg;

  localparam int DEF_AW        = 10;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-way round-robin core: current owner, burst count and requests in,
// next owner and next burst count out. Purely combinational.
module arb_rr2
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  owner_e        owner_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          cpu_req_i,
  input  logic          ext_req_i,
  output owner_e        owner_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cntInc;
  logic          burstOpen;

  // The counter saturates so a lone requester can hold the RAM indefinitely.
  assign cntInc    = (cnt_i == CNT_MAX) ? cnt_i : cnt_i + CNT_ONE;
  assign burstOpen = (cnt_i < CNT_MAX);

  always_comb begin
    owner_o = OWN_NONE;
    cnt_o   = '0;
    case (owner_i)
      OWN_CPU: begin
        if (cpu_req_i && (!ext_req_i || burstOpen)) begin
          owner_o = OWN_CPU;
          cnt_o   = cntInc;
        end else if (ext_req_i) begin
          owner_o = OWN_EXT;
          cnt_o   = CNT_ONE;
        end
      end
      OWN_EXT: begin
        if (ext_req_i && (!cpu_req_i || burstOpen)) begin
          owner_o = OWN_EXT;
          cnt_o   = cntInc;
        end else if (cpu_req_i) begin
          owner_o = OWN_CPU;
          cnt_o   = CNT_ONE;
        end
      end
      default: begin
        // From idle the CPU wins a simultaneous request.
        if (cpu_req_i) begin
          owner_o = OWN_CPU;
          cnt_o   = CNT_ONE;
        end else if (ext_req_i) begin
          owner_o = OWN_EXT;
          cnt_o   = CNT_ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU and an external requester,
// muxing the RAM port and steering the one-cycle-late read data back.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdCpu_q, rdCpu_d;
  logic          rdExt_q, rdExt_d;

  arb_rr2 #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_rr2 (
    .owner_i   (owner_q),
    .cnt_i     (cnt_q),
    .cpu_req_i (cpu_req),
    .ext_req_i (ext_req),
    .owner_o   (owner_d),
    .cnt_o     (cnt_d)
  );

  // Grants are masked while reset is held so nothing reaches the RAM.
  assign cpu_gnt   = rst && (owner_d == OWN_CPU);
  assign ext_gnt   = rst && (owner_d == OWN_EXT);
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (ext_gnt) begin
      ram_addr  = ext_addr;
      ram_wdata = ext_wdata;
      ram_we    = ext_we;
    end
  end

  assign rdCpu_d = cpu_gnt && !cpu_we;
  assign rdExt_d = ext_gnt && !ext_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      rdCpu_q <= 1'b0;
      rdExt_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdCpu_q <= rdCpu_d;
      rdExt_q <= rdExt_d;
    end
  end

  // Read tags line up with the RAM's one-cycle read latency.
  assign cpu_rvalid = rdCpu_q;
  assign ext_rvalid = rdExt_q;
  assign cpu_rdata  = rdCpu_q ? ram_rdata : '0;
  assign ext_rdata  = rdExt_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a synchronous RAM model
// and a shadow memory maintained from the granted requests.
module tb_dmem_arbiter;

  localparam int AW        = 10;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ext_req, ext_we;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [DW-1:0] cpu_rdata, ext_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] shadow [0:1023];

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive both ports just after the edge, then let logic settle.
  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [AW-1:0] cAddr,
                               input logic [DW-1:0] cWd, input logic eReq, input logic eWe,
                               input logic [AW-1:0] eAddr, input logic [DW-1:0] eWd);
    @(posedge clk);
    #1;
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWd;
    ext_req = eReq; ext_we = eWe; ext_addr = eAddr; ext_wdata = eWd;
    #2;
  endtask

  logic          lastCpuGnt, lastExtGnt, expCpuV, expExtV;
  logic [DW-1:0] expRd;
  int            cpuWait, extWait;

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    #1;
    rst = 1'b0;
    cpu_req = 1'b1;
    ext_req = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E3779B1;
    mem[16] = 32'hDEADBEEF;
    mem[1]  = 32'hA5A50001;
    mem[2]  = 32'h5A5A0002;
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    #1;
    $display("[TB] reset state");
    checkOutput("rst_cpu_gnt", cpu_gnt, 0);
    checkOutput("rst_ext_gnt", ext_gnt, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_ext_rvalid", ext_rvalid, 0);
    checkOutput("rst_cpu_stall", cpu_stall, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    ext_req = 1'b0;

    $display("[TB] single CPU read");
    applyStimulus(1, 0, 10'h010, 0, 0, 0, 0, 0);
    checkOutput("t1_cpu_gnt", cpu_gnt, 1);
    checkOutput("t1_cpu_stall", cpu_stall, 0);
    checkOutput("t1_ext_gnt", ext_gnt, 0);
    checkOutput("t1_ram_addr", 32'(ram_addr), 32'h010);
    checkOutput("t1_ram_we", ram_we, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("t1_ext_rvalid", ext_rvalid, 0);
    checkOutput("t1_ext_rdata", ext_rdata, 0);
    checkOutput("t1_idle_ram_addr", 32'(ram_addr), 0);

    $display("[TB] contention burst pattern");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 10'(i), 0, 1, 0, 10'(i + 100), 0);
      checkOutput("t2_cpu_gnt", cpu_gnt, (i < 4 || i >= 8) ? 1 : 0);
      checkOutput("t2_ext_gnt", ext_gnt, (i >= 4 && i < 8) ? 1 : 0);
      checkOutput("t2_cpu_stall", cpu_stall, (i >= 4 && i < 8) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] EXT write then CPU read");
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h3FF, 32'h12345678);
    checkOutput("t3_ext_gnt", ext_gnt, 1);
    checkOutput("t3_cpu_gnt", cpu_gnt, 0);
    checkOutput("t3_ram_we", ram_we, 1);
    checkOutput("t3_ram_addr", 32'(ram_addr), 32'h3FF);
    checkOutput("t3_ram_wdata", ram_wdata, 32'h12345678);
    applyStimulus(1, 0, 10'h3FF, 0, 0, 0, 0, 0);
    checkOutput("t3_rd_cpu_gnt", cpu_gnt, 1);
    checkOutput("t3_rd_ram_we", ram_we, 0);
    checkOutput("t3_wr_no_ext_rvalid", ext_rvalid, 0);
    checkOutput("t3_wr_no_cpu_rvalid", cpu_rvalid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("t3_cpu_rdata", cpu_rdata, 32'h12345678);
    checkOutput("t3_ext_rvalid", ext_rvalid, 0);

    $display("[TB] back-to-back reads on alternating ports");
    applyStimulus(1, 0, 10'h001, 0, 0, 0, 0, 0);
    checkOutput("t4_cpu_gnt", cpu_gnt, 1);
    checkOutput("t4_cpu_rvalid0", cpu_rvalid, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 10'h002, 0);
    checkOutput("t4_ext_gnt", ext_gnt, 1);
    checkOutput("t4_cpu_rvalid", cpu_rvalid, 1);
    checkOutput("t4_cpu_rdata", cpu_rdata, 32'hA5A50001);
    checkOutput("t4_ext_rvalid0", ext_rvalid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_ext_rvalid", ext_rvalid, 1);
    checkOutput("t4_ext_rdata", ext_rdata, 32'h5A5A0002);
    checkOutput("t4_cpu_rvalid1", cpu_rvalid, 0);
    checkOutput("t4_cpu_rdata1", cpu_rdata, 0);

    $display("[TB] reset during read in flight");
    applyStimulus(1, 0, 10'h010, 0, 0, 0, 0, 0);
    checkOutput("t5_cpu_gnt", cpu_gnt, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 10'h005; ext_wdata = 32'hFFFFFFFF;
    #2;
    checkOutput("t5_rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("t5_rst_ext_gnt", ext_gnt, 0);
    checkOutput("t5_rst_ram_we", ram_we, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h005, 32'hFFFFFFFF);
    checkOutput("t5_rst2_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("t5_rst2_ext_gnt", ext_gnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ext_we = 1'b0; ext_addr = 10'h002; ext_wdata = '0;
    #2;
    checkOutput("t5_rel_ext_gnt", ext_gnt, 1);
    checkOutput("t5_rel_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("t5_rel_ram_addr", 32'(ram_addr), 32'h002);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_ext_rvalid", ext_rvalid, 1);
    checkOutput("t5_ext_rdata", ext_rdata, 32'h5A5A0002);
    checkOutput("t5_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("t5_mem5_kept", mem[5], shadow[5]);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    lastCpuGnt = 0; lastExtGnt = 0; expCpuV = 0; expExtV = 0; expRd = '0;
    cpuWait = 0; extWait = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      // A requester keeps its request stable until it has been granted.
      if (!(cpu_req && !lastCpuGnt)) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if (!(ext_req && !lastExtGnt)) begin
        ext_req   = ($urandom_range(0, 3) != 0);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = AW'($urandom_range(0, 15));
        ext_wdata = $urandom;
      end
      #2;
      checkOutput("rnd_onehot", cpu_gnt & ext_gnt, 0);
      checkOutput("rnd_cpu_gnt_req", cpu_gnt & ~cpu_req, 0);
      checkOutput("rnd_ext_gnt_req", ext_gnt & ~ext_req, 0);
      checkOutput("rnd_cpu_rvalid", cpu_rvalid, expCpuV);
      checkOutput("rnd_ext_rvalid", ext_rvalid, expExtV);
      checkOutput("rnd_cpu_rdata", cpu_rdata, expCpuV ? expRd : 32'h0);
      checkOutput("rnd_ext_rdata", ext_rdata, expExtV ? expRd : 32'h0);
      if (cpu_gnt) begin
        checkOutput("rnd_ram_we_cpu", ram_we, cpu_we);
        checkOutput("rnd_ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
      end else if (ext_gnt) begin
        checkOutput("rnd_ram_we_ext", ram_we, ext_we);
        checkOutput("rnd_ram_addr_ext", 32'(ram_addr), 32'(ext_addr));
      end else begin
        checkOutput("rnd_ram_we_idle", ram_we, 0);
      end
      cpuWait = (cpu_req && !cpu_gnt) ? cpuWait + 1 : 0;
      extWait = (ext_req && !ext_gnt) ? extWait + 1 : 0;
      checkOutput("rnd_cpu_wait", (cpuWait <= MAX_BURST), 1);
      checkOutput("rnd_ext_wait", (extWait <= MAX_BURST), 1);
      expCpuV = cpu_gnt && !cpu_we;
      expExtV = ext_gnt && !ext_we;
      if (cpu_gnt) begin
        expRd = shadow[cpu_addr];
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      end else if (ext_gnt) begin
        expRd = shadow[ext_addr];
        if (ext_we) shadow[ext_addr] = ext_wdata;
      end
      lastCpuGnt = cpu_gnt;
      lastExtGnt = ext_gnt;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
